// File: rtl/inst_fetch_mod_pkg.sv
// fetch_defs: shared encodings for the instruction fetch front end
package fetch_defs;
  typedef enum logic [2:0] {S_FETCH_OP, S_FETCH_CB, S_FETCH_IMM1, S_FETCH_IMM2, S_READY} state_e;
  localparam logic [7:0] CB_PREFIX = 8'hCB;
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_H = 1;
  localparam int FLAG_C = 0;
  typedef enum logic [1:0] {CC_NZ, CC_Z, CC_NC, CC_C} cond_e;
  typedef enum logic [1:0] {ADV_ZERO = 2'd0, ADV_ONE = 2'd1, ADV_FLAG = 2'd2} adv_sel_e;
  function automatic logic cond_met(input logic [1:0] cc, input logic [3:0] f);
    cond_e c;
    c = cond_e'(cc);
    return c == CC_NZ ? !f[FLAG_Z] : c == CC_Z ? f[FLAG_Z] : c == CC_NC ? !f[FLAG_C] : f[FLAG_C];
  endfunction
endpackage

// File: rtl/inst_length_decode_mod.sv
// inst_length_decode_mod: opcode to number of trailing immediate bytes
module inst_length_decode_mod (
  input  logic [7:0] opcode_i,
  output logic [1:0] imm_cnt_o
);
  // 16-bit loads, jumps, calls and absolute A loads take two bytes; d8/r8/a8 forms take one
  always_comb begin
    case (opcode_i)
      8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hC2, 8'hC3, 8'hCA, 8'hD2, 8'hDA,
      8'hC4, 8'hCC, 8'hCD, 8'hD4, 8'hDC, 8'hEA, 8'hFA: imm_cnt_o = 2'd2;
      8'h06, 8'h0E, 8'h16, 8'h1E, 8'h26, 8'h2E, 8'h36, 8'h3E,
      8'hC6, 8'hCE, 8'hD6, 8'hDE, 8'hE6, 8'hEE, 8'hF6, 8'hFE,
      8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hE0, 8'hF0, 8'hE8, 8'hF8: imm_cnt_o = 2'd1;
      default: imm_cnt_o = 2'd0;
    endcase
  end
endmodule

// File: rtl/inst_fetch_mod.sv
// inst_fetch_mod: fetches opcode, CB prefix and immediates for the control unit
module inst_fetch_mod #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_PREFIX = fetch_defs::CB_PREFIX
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ready,
  input  logic        inst_done,
  input  logic        pc_load,
  input  logic [15:0] pc_load_value,
  input  logic [3:0]  flags,
  output logic [7:0]  inst_buffer,
  output logic [15:0] imm_word,
  output logic        inst_valid,
  output logic        toggle_cb,
  output logic        flag_adv,
  output logic [15:0] pc
);
  import fetch_defs::*;
  state_e state_q, state_d;
  logic [15:0] pc_q, pc_d, imm_q, imm_d;
  logic [7:0] buf_q, buf_d;
  logic cb_q, cb_d, rd_q, rd_d, tog_q, tog_d, pend_q, pend_d;
  logic [1:0] imm_cnt;
  logic fire, done, op_byte, prefix, want_tog;
  logic unused_flags;
  assign unused_flags = ^flags[2:1];
  assign fire = rd_q & mem_ready;
  assign done = (state_q == S_READY) & inst_done;
  assign op_byte = fire & (state_q == S_FETCH_OP);
  assign prefix = op_byte & (mem_rdata == CB_PREFIX);
  assign want_tog = prefix | (done & cb_q);
  // in IMM1 the stored opcode is decoded again to decide whether a second byte follows
  inst_length_decode_mod u_len (
    .opcode_i  (state_q == S_FETCH_OP ? mem_rdata : buf_q),
    .imm_cnt_o (imm_cnt)
  );
  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_FETCH_OP;
    else state_q <= state_d;
  end
  // next state: advance one step per completed read, return to opcode fetch on retire
  always_comb begin
    state_d = state_q;
    if (done) state_d = S_FETCH_OP;
    else if (fire) begin
      case (state_q)
        S_FETCH_OP:   state_d = prefix ? S_FETCH_CB : imm_cnt == 2'd0 ? S_READY : S_FETCH_IMM1;
        S_FETCH_IMM1: state_d = imm_cnt == 2'd2 ? S_FETCH_IMM2 : S_READY;
        default:      state_d = S_READY;
      endcase
    end
  end
  // datapath next values; a toggle requested right after another is deferred one cycle
  always_comb begin
    pc_d = done ? (pc_load ? pc_load_value : pc_q) : fire ? pc_q + 16'd1 : pc_q;
    buf_d = (op_byte & !prefix) | (fire & state_q == S_FETCH_CB) ? mem_rdata : buf_q;
    imm_d = op_byte ? 16'h0000 :
            fire & state_q == S_FETCH_IMM1 ? {imm_q[15:8], mem_rdata} :
            fire & state_q == S_FETCH_IMM2 ? {mem_rdata, imm_q[7:0]} : imm_q;
    cb_d = prefix ? 1'b1 : done ? 1'b0 : cb_q;
    tog_d = !tog_q & (want_tog | pend_q);
    pend_d = tog_q & (want_tog | pend_q);
    rd_d = state_d != S_READY;
  end
  // datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
      buf_q <= 8'h00;
      imm_q <= 16'h0000;
      cb_q <= 1'b0;
      rd_q <= 1'b0;
      tog_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      buf_q <= buf_d;
      imm_q <= imm_d;
      cb_q <= cb_d;
      rd_q <= rd_d;
      tog_q <= tog_d;
      pend_q <= pend_d;
    end
  end
  // outputs
  always_comb begin
    mem_rd = rd_q;
    mem_addr = pc_q;
    pc = pc_q;
    inst_buffer = buf_q;
    imm_word = imm_q;
    inst_valid = state_q == S_READY;
    toggle_cb = tog_q;
    flag_adv = cond_met(buf_q[4:3], flags);
  end
endmodule

// File: tb/tb_inst_fetch_mod.sv
// tb_inst_fetch_mod: randomized scoreboard bench for the fetch front end
module tb_inst_fetch_mod;
  localparam logic [7:0] CB = 8'hCB;
  logic clock = 0, reset = 0;
  logic [15:0] mem_addr, pc, imm_word, pc_load_value = 0;
  logic mem_rd, inst_valid, toggle_cb, flag_adv;
  logic [7:0] mem_rdata = 0, inst_buffer;
  logic mem_ready = 0, inst_done = 0, pc_load = 0;
  logic [3:0] flags = 0;
  inst_fetch_mod dut (
    .clock(clock), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .inst_done(inst_done), .pc_load(pc_load), .pc_load_value(pc_load_value),
    .flags(flags), .inst_buffer(inst_buffer), .imm_word(imm_word), .inst_valid(inst_valid),
    .toggle_cb(toggle_cb), .flag_adv(flag_adv), .pc(pc)
  );
  always #5 clock = ~clock;
  typedef struct packed {logic [7:0] op; logic [15:0] imm; logic [15:0] pc; logic [15:0] tog;} rec_t;
  logic [7:0] mem [0:65535];
  rec_t exp_q[$];
  logic [15:0] addr_q[$];
  int errors = 0, checks = 0, tog_total = 0, pend_ret = 0, tog_seen = 0;
  logic [15:0] next_pc;
  logic prev_valid = 0, prev_tog = 0;
  logic [7:0] cur_op = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  // immediate byte count by instruction class
  function automatic int ref_len(input logic [7:0] op);
    if (op inside {8'h01, 8'h11, 8'h21, 8'h31, 8'h08, 8'hEA, 8'hFA, 8'hC3, 8'hCD}) return 2;
    if (op[7:5] == 3'b110 && op[0] == 1'b0 && (op[2:1] == 2'b01 || op[2:1] == 2'b10)) return 2;
    if (op[7:6] == 2'b00 && op[2:0] == 3'd6) return 1;
    if (op[7:6] == 2'b11 && op[2:0] == 3'd6) return 1;
    if (op inside {8'h10, 8'h18, 8'h20, 8'h28, 8'h30, 8'h38, 8'hE0, 8'hF0, 8'hE8, 8'hF8}) return 1;
    return 0;
  endfunction
  // branch condition: NZ, Z, NC, C selected by opcode bits 4:3
  function automatic logic ref_cond(input logic [7:0] op, input logic [3:0] f);
    logic z, c;
    z = f[3];
    c = f[0];
    case (op[4:3])
      2'b00: return !z;
      2'b01: return z;
      2'b10: return !c;
      default: return c;
    endcase
  endfunction
  task automatic push_inst(input logic [15:0] a);
    rec_t r;
    int n;
    logic [7:0] op;
    op = mem[a];
    tog_total += pend_ret;
    pend_ret = 0;
    r.imm = 16'h0000;
    if (op == CB) begin
      r.op = mem[a + 16'd1];
      n = 1;
      tog_total++;
      pend_ret = 1;
    end else begin
      r.op = op;
      n = ref_len(op);
      if (n > 0) r.imm[7:0] = mem[a + 16'd1];
      if (n > 1) r.imm[15:8] = mem[a + 16'd2];
    end
    for (int i = 0; i <= n; i++) addr_q.push_back(a + 16'(i));
    r.pc = a + 16'(n + 1);
    r.tog = 16'(tog_total);
    exp_q.push_back(r);
    next_pc = r.pc;
  endtask
  // memory with random wait states and random ALU flags
  initial forever begin
    @(posedge clock);
    #1;
    mem_ready = $urandom_range(0, 3) != 0;
    mem_rdata = mem[mem_addr];
    flags = 4'($urandom);
  end
  // monitor: reads, toggles, and instruction presentation against the scoreboard
  always @(negedge clock) begin
    if (!reset) begin
      prev_valid = 0;
      prev_tog = 0;
    end else begin
      check("toggle_gap", 32'(toggle_cb & prev_tog), 0);
      tog_seen += int'(toggle_cb);
      if (mem_rd && mem_ready) begin
        if (addr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL read_unexpected: got read at %h expected none", mem_addr);
        end else check("read_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
      if (inst_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL valid_unexpected: got inst %h expected none", inst_buffer);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          cur_op = r.op;
          check("inst_buffer", 32'(inst_buffer), 32'(r.op));
          check("imm_word", 32'(imm_word), 32'(r.imm));
          check("pc", 32'(pc), 32'(r.pc));
          check("toggle_count", 32'(tog_seen), 32'(r.tog));
        end
      end
      if (inst_valid) begin
        check("flag_adv", 32'(flag_adv), 32'(ref_cond(cur_op, flags)));
        check("rd_in_ready", 32'(mem_rd), 0);
      end
      prev_valid = inst_valid;
      prev_tog = toggle_cb;
    end
  end
  // control unit: wait for the instruction, dawdle with ignored pc_loads, then retire
  task automatic retire(input bit force_load, input logic [15:0] tgt, output bit ok);
    int t;
    bit ld;
    logic [15:0] target;
    t = 0;
    ok = 1;
    while (!inst_valid && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (t >= 300) begin
      check("valid_timeout", 32'(t), 0);
      ok = 0;
      return;
    end
    repeat ($urandom_range(0, 3)) begin
      @(posedge clock);
      #1;
      pc_load = 1'($urandom);
      pc_load_value = 16'($urandom);
    end
    ld = force_load || $urandom_range(0, 2) == 0;
    target = force_load ? tgt : 16'($urandom);
    push_inst(ld ? target : next_pc);
    @(posedge clock);
    #1;
    inst_done = 1;
    pc_load = ld;
    pc_load_value = target;
    @(posedge clock);
    #1;
    inst_done = 1'($urandom);
    pc_load = inst_done;
    pc_load_value = 16'($urandom);
    @(posedge clock);
    #1;
    inst_done = 0;
    pc_load = 0;
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_rd"}, 32'(mem_rd), 0);
    check({tag, "_inst_valid"}, 32'(inst_valid), 0);
    check({tag, "_toggle_cb"}, 32'(toggle_cb), 0);
    check({tag, "_pc"}, 32'(pc), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_inst_buffer"}, 32'(inst_buffer), 0);
    check({tag, "_imm_word"}, 32'(imm_word), 0);
  endtask
  initial begin
    bit ok;
    int t;
    for (int i = 0; i < 65536; i++) mem[i] = $urandom_range(0, 5) == 0 ? CB : 8'($urandom);
    mem[16'h0000] = 8'h00;
    mem[16'hFFFF] = 8'h3E;
    mem[16'h4000] = 8'h01;
    repeat (2) @(negedge clock);
    check_reset_outputs("reset");
    push_inst(16'h0000);
    reset = 1;
    @(negedge clock);
    check("first_rd", 32'(mem_rd), 1);
    for (int i = 0; i < 150; i++) begin
      retire(0, 16'h0000, ok);
      if (!ok) break;
    end
    retire(1, 16'h4000, ok);
    t = 0;
    while (addr_q.size() > 2 && t < 300) begin
      @(negedge clock);
      t++;
    end
    check("imm_wait", 32'(t < 300), 1);
    @(negedge clock);
    reset = 0;
    #1;
    check_reset_outputs("midfetch");
    addr_q.delete();
    exp_q.delete();
    pend_ret = 0;
    mem[16'h0000] = 8'h7F;
    push_inst(16'h0000);
    @(negedge clock);
    reset = 1;
    retire(1, 16'hFFFF, ok);
    retire(0, 16'h0000, ok);
    t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    @(negedge clock);
    check("drain", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
